// File: rtl/snn_frame_sequencer.sv
// Frame sequencer for one spiking-network inference: assembles the image from
// mailbox chunks, pulses start, gates the spike clock and latches the result.
module snn_frame_sequencer #(
  parameter int WORDS_PER_CHUNK  = 14,
  parameter int LAST_CHUNK_WORDS = 11,
  parameter int NUM_CHUNKS       = 2,
  parameter int IMG_BITS         = 800,
  parameter int RUN_CYCLES       = 1024,
  parameter int OUT_W            = 2
) (
  input  logic                          iCLK,
  input  logic                          iRESETn,
  input  logic                          iNEXT,
  input  logic                          iFINISH,
  input  logic [WORDS_PER_CHUNK*32-1:0] iDATA,
  output logic [IMG_BITS-1:0]           oIMAGE,
  output logic                          oSTART,
  output logic                          oSPIKE_EN,
  input  logic [OUT_W-1:0]              iNEURON_OUT,
  output logic [OUT_W-1:0]              oRESULT,
  output logic                          oRESULT_VALID,
  output logic                          oBUSY,
  output logic                          oDROPPED
);

  localparam int              CHUNK_BITS = WORDS_PER_CHUNK * 32;
  localparam int              CIW        = $clog2(NUM_CHUNKS + 1);
  localparam logic [CIW-1:0]  MAX_IDX    = CIW'(NUM_CHUNKS);
  localparam logic [15:0]     RUN_LOAD   = 16'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CIW-1:0]      chunk_idx_q, chunk_idx_d;
  logic [15:0]         run_cnt_q, run_cnt_d;
  logic [IMG_BITS-1:0] image_q, image_d;
  logic [OUT_W-1:0]    result_q, result_d;
  logic                valid_q, valid_d;
  logic                nxt_q;
  logic                start_q, start_d;
  logic                spike_q, spike_d;
  logic                busy_q, busy_d;
  logic                drop_q, drop_d;
  logic                accept_s;
  logic                wr_en_s;
  int                  n_words_s;

  assign accept_s  = iNEXT & ~nxt_q;
  assign n_words_s = iFINISH ? LAST_CHUNK_WORDS : WORDS_PER_CHUNK;

  // Next-state, counters and result latch
  always_comb begin
    state_d     = state_q;
    chunk_idx_d = chunk_idx_q;
    run_cnt_d   = run_cnt_q;
    result_d    = result_q;
    valid_d     = valid_q;
    drop_d      = 1'b0;
    wr_en_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s && (chunk_idx_q < MAX_IDX)) begin
          wr_en_s = 1'b1;
          valid_d = 1'b0;
          if (iFINISH) begin
            state_d     = S_ARM;
            chunk_idx_d = '0;
          end else begin
            chunk_idx_d = chunk_idx_q + CIW'(1);
          end
        end else if (accept_s) begin
          // Overflowed image: swallow chunks until the host closes the frame.
          drop_d      = 1'b1;
          chunk_idx_d = iFINISH ? '0 : chunk_idx_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARM: begin
        drop_d  = accept_s;
        state_d = S_START;
      end
      S_START: begin
        drop_d    = accept_s;
        run_cnt_d = RUN_LOAD;
        state_d   = S_RUN;
      end
      S_RUN: begin
        drop_d = accept_s;
        if (run_cnt_q == 16'd0) begin
          state_d = S_DONE;
        end else begin
          run_cnt_d = run_cnt_q - 16'd1;
        end
      end
      S_DONE: begin
        drop_d   = accept_s;
        result_d = iNEURON_OUT;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    start_d = (state_d == S_START);
    spike_d = (state_d == S_RUN);
    busy_d  = (state_d != S_IDLE);
  end

  // Per-bit image write: bit p belongs to chunk p/CHUNK_BITS, word (p%CHUNK_BITS)/32
  always_comb begin
    image_d = image_q;
    for (int p = 0; p < IMG_BITS; p++) begin
      if (wr_en_s && (int'(chunk_idx_q) == (p / CHUNK_BITS)) &&
          (((p % CHUNK_BITS) / 32) < n_words_s)) begin
        image_d[p] = iDATA[p % CHUNK_BITS];
      end else begin
        image_d[p] = image_q[p];
      end
    end
  end

  // State and output registers
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q     <= S_IDLE;
      chunk_idx_q <= '0;
      run_cnt_q   <= 16'd0;
      image_q     <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      nxt_q       <= 1'b0;
      start_q     <= 1'b0;
      spike_q     <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chunk_idx_q <= chunk_idx_d;
      run_cnt_q   <= run_cnt_d;
      image_q     <= image_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      nxt_q       <= iNEXT;
      start_q     <= start_d;
      spike_q     <= spike_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
    end
  end

  assign oIMAGE        = image_q;
  assign oSTART        = start_q;
  assign oSPIKE_EN     = spike_q;
  assign oRESULT       = result_q;
  assign oRESULT_VALID = valid_q;
  assign oBUSY         = busy_q;
  assign oDROPPED      = drop_q;

endmodule

// File: tb/tb_snn_frame_sequencer.sv
// Randomized self-checking bench for snn_frame_sequencer against a
// transaction-level model of image assembly and inference timing.
module tb_snn_frame_sequencer;

  localparam int WPC   = 14;
  localparam int LASTW = 11;
  localparam int NCH   = 2;
  localparam int IMG   = 800;
  localparam int RUNC  = 8;
  localparam int OW    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              nxt = 1'b0;
  logic              fin = 1'b0;
  logic [WPC*32-1:0] data = '0;
  logic [IMG-1:0]    image;
  logic              start, spike_en, res_valid, busy, dropped;
  logic [OW-1:0]     neuron = '0;
  logic [OW-1:0]     result;

  int n_tests = 0;
  int n_fail  = 0;

  logic [IMG-1:0] m_img;
  int             m_idx;
  logic           m_valid;
  logic [OW-1:0]  m_result;

  snn_frame_sequencer #(
    .WORDS_PER_CHUNK(WPC), .LAST_CHUNK_WORDS(LASTW), .NUM_CHUNKS(NCH),
    .IMG_BITS(IMG), .RUN_CYCLES(RUNC), .OUT_W(OW)
  ) dut (
    .iCLK(clk), .iRESETn(rst_n), .iNEXT(nxt), .iFINISH(fin), .iDATA(data),
    .oIMAGE(image), .oSTART(start), .oSPIKE_EN(spike_en),
    .iNEURON_OUT(neuron), .oRESULT(result), .oRESULT_VALID(res_valid),
    .oBUSY(busy), .oDROPPED(dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [IMG-1:0] got, input logic [IMG-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WPC*32-1:0] rand_chunk();
    logic [WPC*32-1:0] d;
    for (int k = 0; k < WPC; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_reset();
    m_img = '0; m_idx = 0; m_valid = 1'b0; m_result = '0;
  endtask

  // Reference: an idle-time chunk either lands at its slot or is dropped on overflow
  task automatic model_accept(input logic f, input logic [WPC*32-1:0] d,
                              output bit run, output bit drop);
    int n;
    run = 0; drop = 0;
    if (m_idx < NCH) begin
      n = f ? LASTW : WPC;
      for (int k = 0; k < n; k++)
        for (int b = 0; b < 32; b++)
          if (m_idx*WPC*32 + k*32 + b < IMG) m_img[m_idx*WPC*32 + k*32 + b] = d[k*32 + b];
      m_valid = 1'b0;
      if (f) begin m_idx = 0; run = 1; end
      else m_idx++;
    end else begin
      drop = 1;
      if (f) m_idx = 0;
    end
  endtask

  // Presents one chunk with a single-cycle iNEXT pulse; returns one cycle after the accept edge
  task automatic send(input logic f, input logic [WPC*32-1:0] d);
    @(negedge clk);
    data = d; fin = f; nxt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic send_and_check(input string tag, input logic f, input logic [WPC*32-1:0] d,
                                output bit run);
    bit drop;
    send(f, d);
    model_accept(f, d, run, drop);
    chk({tag, ".drop"}, IMG'(dropped), IMG'(drop));
    chk({tag, ".busy"}, IMG'(busy), IMG'(run));
    chk({tag, ".valid"}, IMG'(res_valid), IMG'(m_valid));
    chk({tag, ".img"}, image, m_img);
  endtask

  // Observes one inference from the cycle after the FINISH accept
  task automatic run_check(input string tag, input bit toggle);
    int starts = 0, spikes = 0, drops = 0;
    int first_start = -1, first_spike = -1, first_valid = -1;
    for (int s = 0; s < 15; s++) begin
      if (s > 0) @(negedge clk);
      if (start) begin starts++; if (first_start < 0) first_start = s; end
      if (spike_en) begin spikes++; if (first_spike < 0) first_spike = s; end
      if (res_valid && first_valid < 0) first_valid = s;
      if (s > 0 && dropped) drops++;
      if (toggle && s == 4) begin data = rand_chunk(); nxt = 1'b1; end
      if (s == 5) nxt = 1'b0;
    end
    chk({tag, ".starts"}, IMG'(starts), IMG'(1));
    chk({tag, ".start_at"}, IMG'(first_start), IMG'(1));
    chk({tag, ".spikes"}, IMG'(spikes), IMG'(RUNC));
    chk({tag, ".spike_at"}, IMG'(first_spike), IMG'(2));
    chk({tag, ".valid_at"}, IMG'(first_valid), IMG'(RUNC + 3));
    chk({tag, ".drops"}, IMG'(drops), IMG'(toggle ? 1 : 0));
    chk({tag, ".result"}, IMG'(result), IMG'(neuron));
    chk({tag, ".busy_end"}, IMG'(busy), IMG'(0));
    chk({tag, ".img_end"}, image, m_img);
    m_valid = 1'b1; m_result = neuron;
  endtask

  initial begin
    logic [WPC*32-1:0] d;
    logic [WPC*32-1:0] d_hold;
    bit run;
    int drops;
    bit f;
    bit tg;

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.img", image, '0);
    chk("rst.outs", IMG'({start, spike_en, res_valid, busy, dropped, result}), '0);
    rst_n = 1'b1;

    // Two-chunk image with fixed word patterns
    for (int k = 0; k < WPC; k++) d[k*32 +: 32] = 32'hA000_0000 + 32'(k);
    send_and_check("two.c0", 1'b0, d, run);
    for (int k = 0; k < WPC; k++) d[k*32 +: 32] = 32'hB000_0000 + 32'(k);
    neuron = 2'b10;
    send_and_check("two.c1", 1'b1, d, run);
    chk("two.w0", IMG'(image[31:0]), IMG'(32'hA000_0000));
    chk("two.w14", IMG'(image[479:448]), IMG'(32'hB000_0000));
    chk("two.w24", IMG'(image[799:768]), IMG'(32'hB000_000A));
    run_check("two", 1'b0);
    chk("two.res2", IMG'(result), IMG'(2));

    // Single FINISH chunk with a 7-bit pattern in word 0
    d = rand_chunk();
    d[6:0] = 7'b1010101;
    neuron = 2'b01;
    send_and_check("one", 1'b1, d, run);
    chk("one.bits", IMG'(image[6:0]), IMG'(7'b1010101));
    run_check("one", 1'b0);

    // iNEXT edge during RUN is dropped
    neuron = 2'b11;
    send_and_check("tog", 1'b1, rand_chunk(), run);
    run_check("tog", 1'b1);

    // Overflow: third non-final chunk and the closing FINISH chunk are both dropped
    send_and_check("ovf.c0", 1'b0, rand_chunk(), run);
    send_and_check("ovf.c1", 1'b0, rand_chunk(), run);
    send_and_check("ovf.c2", 1'b0, rand_chunk(), run);
    send_and_check("ovf.fin", 1'b1, rand_chunk(), run);
    neuron = 2'b00;
    send_and_check("ovf.next", 1'b1, rand_chunk(), run);
    run_check("ovf", 1'b0);

    // iNEXT held high for 20 cycles yields exactly one accept
    d_hold = rand_chunk();
    @(negedge clk);
    data = d_hold; fin = 1'b0; nxt = 1'b1;
    drops = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dropped) drops++;
      data = rand_chunk();
    end
    nxt = 1'b0;
    model_accept(1'b0, d_hold, run, tg);
    chk("hold.drops", IMG'(drops), IMG'(0));
    chk("hold.img", image, m_img);
    neuron = 2'b10;
    send_and_check("hold.fin", 1'b1, rand_chunk(), run);
    run_check("hold", 1'b0);

    // Asynchronous reset in the middle of RUN
    neuron = 2'b01;
    send_and_check("arst", 1'b1, rand_chunk(), run);
    repeat (4) @(negedge clk);
    chk("arst.in_run", IMG'(spike_en), IMG'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst.img", image, '0);
    chk("arst.outs", IMG'({start, spike_en, res_valid, busy, dropped, result}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (12) @(negedge clk);
    chk("arst.idle", IMG'({busy, spike_en, res_valid}), '0);
    send_and_check("arst.after", 1'b1, rand_chunk(), run);
    run_check("arst.after", 1'b0);

    // Random chunk streams
    for (int i = 0; i < 30; i++) begin
      f = ($urandom_range(0, 2) == 0);
      neuron = OW'($urandom_range(0, 3));
      send_and_check("rnd", f, rand_chunk(), run);
      if (run) begin
        tg = ($urandom_range(0, 1) == 1);
        run_check("rnd", tg);
      end
      chk("rnd.result", IMG'({res_valid, result}), IMG'({m_valid, m_result}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_frame_sequencer.md
Name: snn_frame_sequencer

Overview:
Sequences one inference of the spiking-network datapath (run_network). Assembles an image from 32-bit JTAG mailbox words delivered in chunks, then issues the start pulse. It gates the network's spike clock for a fixed run length, captures the neuron output and reports the result back to the JTAG side. It replaces ad-hoc glue between the MyDesign mailbox and the network with a single-clock state machine.

Parameters:
WORDS_PER_CHUNK, 14, mailbox words offered per chunk
LAST_CHUNK_WORDS, 11, words used from the final chunk
NUM_CHUNKS, 2, maximum chunks per image
IMG_BITS, 800, image register width; must be ≤ NUM_CHUNKS*WORDS_PER_CHUNK*32
RUN_CYCLES, 1024, spike-clock enable cycles per inference; ≥1, fits in 16 bits
OUT_W, 2, neuron output width

Ports:
iCLK  in  1  system clock; wCLK8 in top
iRESETn  in  1  asynchronous active-low reset
iNEXT  in  1  level from host; rising edge = chunk available
iFINISH  in  1  qualifies current chunk as last; sampled with iNEXT edge
iDATA  in  WORDS_PER_CHUNK*32  word k at [32k+31:32k]
oIMAGE  out  IMG_BITS  assembled pixel vector to network
oSTART  out  1  one-cycle start pulse to network
oSPIKE_EN  out  1  clock enable for the network's spike clock
iNEURON_OUT  in  OUT_W  network output
oRESULT  out  OUT_W  latched inference result
oRESULT_VALID  out  1  result held valid
oBUSY  out  1  high from ARM through DONE
oDROPPED  out  1  one-cycle pulse: chunk edge rejected

Behaviour:
- Reset: all outputs 0, oIMAGE cleared, chunk_idx=0, state IDLE, edge-detect register 0. Assertion mid-run aborts immediately; no result is produced.
- Edge detect: nxt_q registers iNEXT. accept = iNEXT & ~nxt_q. iNEXT is synchronous to iCLK.
- States: IDLE, ARM, START, RUN, DONE.
- IDLE + accept, chunk_idx < NUM_CHUNKS:
  - n = iFINISH ? LAST_CHUNK_WORDS : WORDS_PER_CHUNK.
  - Words 0..n-1 are written to oIMAGE at bit offset chunk_idx*WORDS_PER_CHUNK*32 + 32k. Bits ≥ IMG_BITS are discarded.
  - Unwritten image bits keep their previous value.
  - oRESULT_VALID clears.
  - If iFINISH: go to ARM and reset chunk_idx to 0. Otherwise increment chunk_idx.
- IDLE + accept, chunk_idx == NUM_CHUNKS (overflow): data is ignored, oDROPPED pulses, chunk_idx is held until a FINISH chunk arrives. That FINISH chunk is also dropped, resets chunk_idx to 0 and stays in IDLE.
- accept in ARM/START/RUN/DONE: ignored, oDROPPED pulses, no image write.
- ARM: one cycle, oSPIKE_EN=0, lets oIMAGE settle. Go to START.
- START: oSTART=1 for exactly this cycle, oSPIKE_EN=0. Go to RUN and load run_cnt=RUN_CYCLES-1.
- RUN: oSPIKE_EN=1 each cycle. Decrement run_cnt. At 0, go to DONE.
- DONE: oRESULT<=iNEURON_OUT, oRESULT_VALID<=1, oSPIKE_EN=0. Go to IDLE.
- oBUSY=1 in ARM, START, RUN, DONE.
- Timing: FINISH accept at edge N:
  - image written and state=ARM at N+1
  - oSTART high during N+2
  - oSPIKE_EN high during N+3 .. N+2+RUN_CYCLES
  - DONE at N+3+RUN_CYCLES
  - oRESULT_VALID high from N+4+RUN_CYCLES
- oRESULT/oRESULT_VALID hold until the next accepted chunk or reset.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
- Reset values: assert iRESETn=0 mid-RUN. All outputs go to 0 without waiting for an iCLK edge. After release, state is IDLE.
- Two-chunk image (IMG_BITS=800, RUN_CYCLES=8):
  - Chunk 0: word k=32'hA0000000+k, FINISH=0.
  - Chunk 1: word k=32'hB0000000+k, FINISH=1.
  - Required: oIMAGE[31:0]=A0000000, oIMAGE[479:448]=B0000000, oIMAGE[799:768]=B000000A.
  - Words 11–13 of chunk 1 are not written.
  - oSTART is high exactly 1 cycle. oSPIKE_EN is high exactly 8 cycles.
  - With iNEURON_OUT=2'b10: oRESULT=2, oRESULT_VALID high at N+12.
- Single FINISH chunk: write a 7-bit test image 7'b1010101 in word 0. oIMAGE[6:0]=1010101, then the full run sequence; bits ≥352 are untouched.
- iNEXT toggled during RUN: oDROPPED pulses once, oIMAGE is unchanged, oSPIKE_EN count stays 8.
- Overflow: three FINISH=0 chunks. The third gives oDROPPED and no image change. The following FINISH chunk is dropped, chunk_idx returns to 0, oBUSY stays 0.
- iNEXT held high for 20 cycles: exactly one accept. A new chunk requires iNEXT low for ≥1 cycle.
